// File: rtl/batcharger_ctr.sv
// Battery charge controller: sequences the power stage through trickle,
// constant-current and constant-voltage modes, ending on end-current or timeout.
module batcharger_ctr #(
  parameter int NDEB  = 4,
  parameter int PRESC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] vbat,
  input  logic [7:0] ibat,
  input  logic [7:0] vtok,
  input  logic [7:0] vpreset,
  input  logic [7:0] vcutoff,
  input  logic [7:0] iend,
  input  logic [7:0] icfg,
  input  logic [7:0] itcfg,
  input  logic [7:0] tmax,
  output logic       cc,
  output logic       tc,
  output logic       cv,
  output logic       pwr_en,
  output logic [7:0] icc,
  output logic [7:0] itc,
  output logic [7:0] vcv,
  output logic       done,
  output logic       tout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TC   = 3'd1,
    S_CC   = 3'd2,
    S_CV   = 3'd3,
    S_DONE = 3'd4
  } st_t;

  st_t              st, nxt;
  logic [3:0]       cnt, cnt_nx;
  logic [PRESC-1:0] presc, presc_nx;
  logic [7:0]       timer, timer_nx;
  logic [7:0]       vtok_s, vpreset_s, iend_s, tmax_s;
  logic             done_nx, tout_nx, capture;
  logic             cond, active, tmo, fire;

  // Qualifying condition of the current state, always against snapshot thresholds
  always_comb begin
    cond = 1'b0;
    case (st)
      S_TC:    cond = (vbat >= vtok_s);
      S_CC:    cond = (vbat >= vpreset_s);
      S_CV:    cond = (ibat <= iend_s);
      S_DONE:  cond = (vbat < vpreset_s) && !tout;
      default: cond = 1'b0;
    endcase
    active = (st == S_TC) || (st == S_CC) || (st == S_CV);
    tmo    = active && (tmax_s != 8'd0) && (timer == tmax_s);
    fire   = cond && (cnt == 4'(NDEB - 1));
  end

  always_comb begin
    nxt      = st;
    cnt_nx   = cnt;
    presc_nx = presc;
    timer_nx = timer;
    done_nx  = done;
    tout_nx  = tout;
    capture  = 1'b0;
    if (!en) begin
      nxt      = S_IDLE;
      cnt_nx   = 4'd0;
      presc_nx = '0;
      timer_nx = 8'd0;
      done_nx  = 1'b0;
      tout_nx  = 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (vbat >= vcutoff) begin
            nxt     = S_DONE;
            done_nx = 1'b1;
          end else begin
            nxt      = (vbat < vtok) ? S_TC : S_CC;
            capture  = 1'b1;
            presc_nx = '0;
            timer_nx = 8'd0;
          end
        end
        S_TC, S_CC, S_CV: begin
          presc_nx = presc + 1'b1;
          if ((&presc) && (timer != 8'hff))
            timer_nx = timer + 8'd1;
          // Timeout wins over any debounced transition in the same cycle
          if (tmo) begin
            nxt     = S_DONE;
            tout_nx = 1'b1;
            done_nx = 1'b0;
          end else if (fire) begin
            case (st)
              S_TC:    nxt = S_CC;
              S_CC:    nxt = S_CV;
              default: begin
                nxt     = S_DONE;
                done_nx = 1'b1;
              end
            endcase
          end
        end
        S_DONE: begin
          if (fire) begin
            nxt     = S_IDLE;
            done_nx = 1'b0;
          end
        end
        default: nxt = S_IDLE;
      endcase
      if (nxt != st)
        cnt_nx = 4'd0;
      else if (cond)
        cnt_nx = cnt + 4'd1;
      else
        cnt_nx = 4'd0;
    end
  end

  // Mode outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_IDLE;
      cnt       <= 4'd0;
      presc     <= '0;
      timer     <= 8'd0;
      cc        <= 1'b0;
      tc        <= 1'b0;
      cv        <= 1'b0;
      pwr_en    <= 1'b0;
      done      <= 1'b0;
      tout      <= 1'b0;
      icc       <= 8'd0;
      itc       <= 8'd0;
      vcv       <= 8'd0;
      vtok_s    <= 8'd0;
      vpreset_s <= 8'd0;
      iend_s    <= 8'd0;
      tmax_s    <= 8'd0;
    end else begin
      st     <= nxt;
      cnt    <= cnt_nx;
      presc  <= presc_nx;
      timer  <= timer_nx;
      tc     <= (nxt == S_TC);
      cc     <= (nxt == S_CC);
      cv     <= (nxt == S_CV);
      pwr_en <= (nxt == S_TC) || (nxt == S_CC) || (nxt == S_CV);
      done   <= done_nx;
      tout   <= tout_nx;
      if (capture) begin
        icc       <= icfg;
        itc       <= itcfg;
        vcv       <= vcutoff;
        vtok_s    <= vtok;
        vpreset_s <= vpreset;
        iend_s    <= iend;
        tmax_s    <= tmax;
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_batcharger_ctr.sv
// Directed bench for batcharger_ctr: table-driven full charge plus
// hand-written debounce, timeout, recharge, boundary and abort sequences.
module tb_batcharger_ctr;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] vbat, ibat, vtok, vpreset, vcutoff, iend, icfg, itcfg, tmax;
  logic       cc, tc, cv, pwr_en, done, tout;
  logic [7:0] icc, itc, vcv;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  batcharger_ctr #(.NDEB(4), .PRESC(2)) dut (
    .clk(clk), .rst(rst), .en(en), .vbat(vbat), .ibat(ibat),
    .vtok(vtok), .vpreset(vpreset), .vcutoff(vcutoff), .iend(iend),
    .icfg(icfg), .itcfg(itcfg), .tmax(tmax),
    .cc(cc), .tc(tc), .cv(cv), .pwr_en(pwr_en),
    .icc(icc), .itc(itc), .vcv(vcv),
    .done(done), .tout(tout), .state(state)
  );

  typedef struct {
    logic       e;
    logic [7:0] vb;
    logic [7:0] ib;
    int         s;
    bit         d;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [8:0] got();
    return {state, cc, tc, cv, pwr_en, done, tout};
  endfunction

  // Expected observable outputs for a state plus done/tout flags
  function automatic logic [8:0] ex(int s, bit d, bit t);
    logic [2:0] s3;
    s3 = 3'(s);
    return {s3, s == 2, s == 1, s == 3, (s >= 1 && s <= 3), d, t};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [7:0] vb, input logic [7:0] ib);
    en   = e;
    vbat = vb;
    ibat = ib;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((int'(cc) + int'(tc) + int'(cv)) > 1) begin
        errors++;
        $display("FAIL onehot: got cc=%0b tc=%0b cv=%0b expected at most one set", cc, tc, cv);
      end
    end
  end

  initial begin
    tbl[0]  = '{1'b1, 8'd100, 8'd50, 1, 1'b0};
    tbl[1]  = '{1'b1, 8'd160, 8'd50, 1, 1'b0};
    tbl[2]  = '{1'b1, 8'd160, 8'd50, 1, 1'b0};
    tbl[3]  = '{1'b1, 8'd160, 8'd50, 1, 1'b0};
    tbl[4]  = '{1'b1, 8'd160, 8'd50, 2, 1'b0};
    tbl[5]  = '{1'b1, 8'd170, 8'd40, 2, 1'b0};
    tbl[6]  = '{1'b1, 8'd200, 8'd40, 2, 1'b0};
    tbl[7]  = '{1'b1, 8'd200, 8'd40, 2, 1'b0};
    tbl[8]  = '{1'b1, 8'd200, 8'd40, 2, 1'b0};
    tbl[9]  = '{1'b1, 8'd200, 8'd40, 3, 1'b0};
    tbl[10] = '{1'b1, 8'd205, 8'd30, 3, 1'b0};
    tbl[11] = '{1'b1, 8'd205, 8'd10, 3, 1'b0};
    tbl[12] = '{1'b1, 8'd205, 8'd8,  3, 1'b0};
    tbl[13] = '{1'b1, 8'd205, 8'd5,  3, 1'b0};
    tbl[14] = '{1'b1, 8'd205, 8'd5,  4, 1'b1};

    rst = 1'b1;
    drive(1'b0, 8'd0, 8'd0);
    vtok = 8'd153; vpreset = 8'd194; vcutoff = 8'd214; iend = 8'd10;
    icfg = 8'd100; itcfg = 8'd20; tmax = 8'd0;
    tick();
    tick();
    chk("reset_outputs", 32'(got()), 32'(ex(0, 1'b0, 1'b0)));
    chk("reset_snapshot", {8'd0, icc, itc, vcv}, 32'd0);
    rst = 1'b0;
    tick();

    // Full charge ramp
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].e, tbl[i].vb, tbl[i].ib);
      tick();
      chk($sformatf("charge_vec%0d", i), 32'(got()), 32'(ex(tbl[i].s, tbl[i].d, 1'b0)));
    end
    chk("charge_snapshot", {8'd0, icc, itc, vcv}, {8'd0, 8'd100, 8'd20, 8'd214});

    // Debounce glitch in CC, config change ignored, abort from CV
    drive(1'b0, 8'd180, 8'd50);
    tick();
    chk("abort_done", 32'(got()), 32'(ex(0, 1'b0, 1'b0)));
    drive(1'b1, 8'd180, 8'd50);
    tick();
    chk("glitch_enter_cc", 32'(got()), 32'(ex(2, 1'b0, 1'b0)));
    icfg = 8'd55;
    tick();
    chk("cfg_change_icc", 32'(icc), 32'd100);
    for (int i = 0; i < 3; i++) begin
      vbat = 8'd200;
      tick();
      chk("glitch_pre", 32'(state), 32'd2);
    end
    vbat = 8'd190;
    tick();
    chk("glitch_low", 32'(state), 32'd2);
    vbat = 8'd200;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("glitch_recount", 32'(state), 32'd2);
    end
    tick();
    chk("glitch_cv", 32'(got()), 32'(ex(3, 1'b0, 1'b0)));
    drive(1'b0, 8'd200, 8'd50);
    tick();
    chk("abort_cv", 32'(got()), 32'(ex(0, 1'b0, 1'b0)));
    icfg = 8'd100;

    // Timeout in CC: tmax=3 ticks of 4 cycles
    tmax = 8'd3;
    drive(1'b1, 8'd180, 8'd50);
    tick();
    chk("tmo_enter_cc", 32'(got()), 32'(ex(2, 1'b0, 1'b0)));
    for (int i = 0; i < 12; i++) tick();
    chk("tmo_before", 32'(got()), 32'(ex(2, 1'b0, 1'b0)));
    tick();
    chk("tmo_done", 32'(got()), 32'(ex(4, 1'b0, 1'b1)));
    vbat = 8'd150;
    for (int i = 0; i < 5; i++) tick();
    chk("tmo_latched", 32'(got()), 32'(ex(4, 1'b0, 1'b1)));
    drive(1'b0, 8'd150, 8'd50);
    tick();
    chk("tmo_clear", 32'(got()), 32'(ex(0, 1'b0, 1'b0)));

    // Recharge, then confirm the timer restarted from zero
    drive(1'b1, 8'd200, 8'd50);
    tick();
    chk("rc_enter_cc", 32'(state), 32'd2);
    for (int i = 0; i < 4; i++) tick();
    chk("rc_cv", 32'(state), 32'd3);
    ibat = 8'd5;
    for (int i = 0; i < 4; i++) tick();
    chk("rc_done", 32'(got()), 32'(ex(4, 1'b1, 1'b0)));
    vbat = 8'd190;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rc_hold", 32'(state), 32'd4);
    end
    tick();
    chk("rc_idle", 32'(got()), 32'(ex(0, 1'b0, 1'b0)));
    tick();
    chk("rc_cc", 32'(got()), 32'(ex(2, 1'b0, 1'b0)));
    for (int i = 0; i < 12; i++) tick();
    chk("rc_timer_cleared", 32'(got()), 32'(ex(2, 1'b0, 1'b0)));
    tick();
    chk("rc_timeout", 32'(got()), 32'(ex(4, 1'b0, 1'b1)));
    drive(1'b0, 8'd190, 8'd5);
    tick();
    tmax = 8'd0;

    // Threshold equality boundaries
    drive(1'b1, 8'd214, 8'd50);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("start_full", 32'(got()), 32'(ex(4, 1'b1, 1'b0)));
    end
    drive(1'b0, 8'd153, 8'd50);
    tick();
    drive(1'b1, 8'd153, 8'd50);
    tick();
    chk("start_at_vtok", 32'(state), 32'd2);
    drive(1'b0, 8'd100, 8'd50);
    tick();

    // Reset mid-charge clears snapshots
    drive(1'b1, 8'd100, 8'd50);
    tick();
    chk("rst_pre_tc", 32'(got()), 32'(ex(1, 1'b0, 1'b0)));
    rst = 1'b1;
    tick();
    chk("rst_mid_outputs", 32'(got()), 32'(ex(0, 1'b0, 1'b0)));
    chk("rst_mid_snapshot", {8'd0, icc, itc, vcv}, 32'd0);
    rst = 1'b0;
    en  = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
